r_egress_arb: RTL

Packet-granular round-robin scheduler that drains the four router output FIFOs onto one shared 8-bit egress link. It sits after the per-port output FIFOs, in place of four independent read ports. It reads each packet's header to learn its length and forwards exactly one whole packet per grant. A stall watchdog soft-resets the granted FIFO when the egress link or the FIFO writer hangs mid-packet.

---
 rtl/r_egress_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/r_egress_arb.sv
// Packet-granular round-robin scheduler draining four output FIFOs onto one 8-bit egress link,
// with a stall watchdog that aborts a hung packet and soft-resets its FIFO.
module r_egress_arb #(
  parameter int unsigned NPORT   = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    fifo_empty,
  input  logic [NPORT*DW-1:0] fifo_dout,
  output logic [NPORT-1:0]    read_enb,
  output logic [NPORT-1:0]    grant,
  output logic                eg_valid,
  output logic [DW-1:0]       eg_data,
  output logic                eg_last,
  input  logic                eg_ready,
  output logic [NPORT-1:0]    soft_reset,
  output logic                busy
);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWait, StAbort} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    gnt_q, gnt_d;
  // Seven bits so that L+1 = 64 fits for a maximum-length packet.
  logic [6:0]    rem_q, rem_d;
  logic [7:0]    stall_q, stall_d;
  logic          hdr_q, hdr_d;
  logic [DW-1:0] data_q, data_d;

  logic          pick_vld;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic [DW-1:0] sel_byte;
  logic          stall_expired;

  // Rotating search starting just after the last-served port; no new grant while in reset.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr_q;
    idx      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + k[1:0];
      if (!pick_vld && !fifo_empty[idx] && !reset) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt_q == i[1:0]) sel_byte = fifo_dout[i*DW +: DW];
    end
  end

  assign stall_expired = (stall_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    rem_d      = rem_q;
    stall_d    = stall_q;
    hdr_d      = hdr_q;
    data_d     = data_q;
    read_enb   = '0;
    grant      = '0;
    eg_valid   = 1'b0;
    eg_last    = 1'b0;
    soft_reset = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          gnt_d          = pick;
          grant[pick]    = 1'b1;
          read_enb[pick] = 1'b1;
          hdr_d          = 1'b1;
          state_d        = StLoad;
        end
      end
      StLoad: begin
        grant[gnt_q] = 1'b1;
        data_d       = sel_byte;
        if (hdr_q) begin
          rem_d = {1'b0, sel_byte[7:2]} + 7'd1;
          hdr_d = 1'b0;
        end
        state_d = StSend;
      end
      StSend: begin
        grant[gnt_q] = 1'b1;
        eg_valid     = 1'b1;
        eg_last      = (rem_q == 7'd0);
        if (eg_ready) begin
          if (rem_q == 7'd0) begin
            ptr_d   = gnt_q;
            state_d = StIdle;
          end else if (!fifo_empty[gnt_q]) begin
            read_enb[gnt_q] = 1'b1;
            rem_d           = rem_q - 7'd1;
            state_d         = StLoad;
          end else begin
            rem_d   = rem_q - 7'd1;
            state_d = StWait;
          end
        end else if (stall_expired) begin
          state_d = StAbort;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      StWait: begin
        grant[gnt_q] = 1'b1;
        if (!fifo_empty[gnt_q]) begin
          read_enb[gnt_q] = 1'b1;
          state_d         = StLoad;
        end else if (stall_expired) begin
          state_d = StAbort;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      StAbort: begin
        grant[gnt_q]      = 1'b1;
        soft_reset[gnt_q] = 1'b1;
        ptr_d             = gnt_q;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Every transfer also changes state, so this clears the watchdog in both cases.
    if (state_d != state_q) stall_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      gnt_q   <= 2'd0;
      rem_q   <= '0;
      stall_q <= '0;
      hdr_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
    end
  end

  assign eg_data = data_q;
  assign busy    = (state_q != StIdle);

endmodule
